// File: rtl/arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_n
// Purpose  : N-channel valid/ready arbiter-multiplexer with one registered
//            output stage. The arbitration policy is fixed at elaboration
//            time by MODE:
//              0 = explicit select, 1 = fixed priority (lowest index wins),
//              2 = round robin (search starts one past the last grant).
// Ports    : clock, reset_n        - clock, async active-low reset
//            in_data  [N*WIDTH]    - channel i at [i*WIDTH +: WIDTH]
//            in_valid [N]          - per-channel valid
//            in_ready [N]          - per-channel ready (combinational, one-hot)
//            select   [SEL_W]      - channel index, MODE 0 only
//            out_data [WIDTH]      - registered output word
//            out_valid             - out_data holds an unconsumed word
//            out_ready             - downstream accepts the word this cycle
//            out_src  [SEL_W]      - channel that supplied out_data
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3,
  parameter int MODE  = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   select,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
);

  logic             load;
  logic             take;
  logic             cand_vld;
  logic [SEL_W-1:0] cand_idx;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;

  // The output register can accept a new word when it is empty or being
  // drained this cycle.
  assign load = !out_valid_q || out_ready;

  // cand_vld already includes the candidate's in_valid, so a grant is a
  // transfer. reset_n gates it so no channel sees ready while in reset.
  assign take = reset_n && load && cand_vld;

  generate
    if (MODE == 0) begin : g_sel
      always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        // Out-of-range selects (possible when N is not a power of two)
        // produce no candidate at all.
        if (32'(select) < N) begin
          cand_idx = select;
          cand_vld = in_valid[select];
        end
      end
    end else if (MODE == 1) begin : g_prio
      always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        // Scan downward so the lowest valid index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            cand_vld = 1'b1;
            cand_idx = SEL_W'(i);
          end
        end
      end
    end else begin : g_rr
      logic [SEL_W-1:0] ptr_q, ptr_d;

      always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        // Wrapped region first (indices 0..ptr), then the region above ptr
        // overrides it: the lowest valid index above ptr wins, otherwise
        // the lowest valid index at or below ptr.
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i] && (i <= 32'(ptr_q))) begin
            cand_vld = 1'b1;
            cand_idx = SEL_W'(i);
          end
        end
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i] && (i > 32'(ptr_q))) begin
            cand_vld = 1'b1;
            cand_idx = SEL_W'(i);
          end
        end
      end

      assign ptr_d = take ? cand_idx : ptr_q;

      // Reset to N-1 so the first search after reset starts at channel 0.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          ptr_q <= SEL_W'(N - 1);
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[cand_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(cand_idx)*WIDTH +: WIDTH];
      out_src_d   = cand_idx;
    end else if (out_ready) begin
      // Drained with nothing to replace it; data/src keep the last word.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux_n
// Purpose  : Self-checking bench for arb_mux_n. Four instances run side by
//            side: MODE 0 with N=6, MODE 1 with N=8, MODE 2 with N=8 and
//            MODE 2 with N=5. A reference model predicts in_ready each cycle
//            and pushes the expected word into a per-instance queue on every
//            predicted transfer; the queue front is compared against the
//            registered output while it is valid and popped on handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_mux_n;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [8*W-1:0] d    [4];
  logic [7:0]     v    [4];
  logic [2:0]     sel  [4];
  logic           ordy [4];
  logic [7:0]     rdy  [4];
  logic [W-1:0]   od   [4];
  logic           ov   [4];
  logic [2:0]     os   [4];

  int nm [4] = '{6, 8, 8, 5};
  int md [4] = '{0, 1, 2, 2};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int NK = (k == 0) ? 6 : (k == 3) ? 5 : 8;
    localparam int MK = (k == 0) ? 0 : (k == 1) ? 1 : 2;
    wire [NK-1:0] r;
    assign rdy[k] = 8'(r);
    arb_mux_n #(.WIDTH(W), .N(NK), .SEL_W(3), .MODE(MK)) u_dut (
      .clock     (clk),
      .reset_n   (rst_n),
      .in_data   (d[k][NK*W-1:0]),
      .in_valid  (v[k][NK-1:0]),
      .in_ready  (r),
      .select    (sel[k]),
      .out_data  (od[k]),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .out_src   (os[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: returns the candidate channel or -1.
  function automatic int cand(int mode, int n, logic [7:0] vv, logic [2:0] s, int p);
    if (mode == 0) return (int'(s) < n) ? int'(s) : -1;
    if (mode == 1) begin
      for (int i = 0; i < n; i++) if (vv[i]) return i;
      return -1;
    end
    for (int i = 1; i <= n; i++) if (vv[(p + i) % n]) return (p + i) % n;
    return -1;
  endfunction

  logic [18:0] q    [4][$];
  bit          ovm  [4];
  int          ptrm [4];
  logic [18:0] last [4];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        ovm[k]  = 1'b0;
        ptrm[k] = nm[k] - 1;
        last[k] = '0;
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("m%0d_rst_valid", k), 32'(ov[k]), 32'd0);
        chk($sformatf("m%0d_rst_ready", k), 32'(rdy[k]), 32'd0);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int          c;
        logic [7:0]  er;
        logic [7:0]  mask;
        logic [18:0] e;
        mask = 8'((1 << nm[k]) - 1);
        c    = cand(md[k], nm[k], v[k], sel[k], ptrm[k]);
        er   = ((!ovm[k] || ordy[k]) && (c >= 0) && v[k][c]) ? 8'(1 << c) : 8'd0;
        chk($sformatf("m%0d_in_ready", k), 32'(rdy[k] & mask), 32'(er));
        chk($sformatf("m%0d_out_valid", k), 32'(ov[k]), 32'(ovm[k]));
        if (ovm[k]) begin
          e = q[k][0];
          chk($sformatf("m%0d_out_data", k), 32'(od[k]), 32'(e[15:0]));
          chk($sformatf("m%0d_out_src", k), 32'(os[k]), 32'(e[18:16]));
          if (ordy[k]) begin
            last[k] = q[k].pop_front();
            ovm[k]  = 1'b0;
          end
        end else begin
          chk($sformatf("m%0d_idle_data", k), 32'(od[k]), 32'(last[k][15:0]));
          chk($sformatf("m%0d_idle_src", k), 32'(os[k]), 32'(last[k][18:16]));
        end
        if (er != 8'd0) begin
          q[k].push_back({3'(c), d[k][c*W +: W]});
          ovm[k]  = 1'b1;
          ptrm[k] = c;
        end
      end
    end
  end

  task automatic new_data();
    for (int k = 0; k < 4; k++) d[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      d[k] = '0; v[k] = '0; sel[k] = '0; ordy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: out-of-range select, priority with stall, full round robin,
    // sparse round robin on N=5.
    for (int i = 0; i < 12; i++) begin
      new_data();
      v[0]    = 8'h3F;
      sel[0]  = (i < 2) ? 3'd7 : (i < 5) ? 3'd5 : 3'd2;
      ordy[0] = 1'b1;
      v[1]    = (i == 3) ? 8'hFF : (i == 4) ? 8'h01 : 8'h68;
      sel[1]  = 3'(i);
      ordy[1] = !(i >= 2 && i < 5);
      v[2]    = 8'hFF;
      ordy[2] = 1'b1;
      v[3]    = 8'h12;
      ordy[3] = 1'b1;
      step();
    end

    // Random traffic, including selects beyond N and backpressure.
    for (int i = 0; i < 300; i++) begin
      new_data();
      for (int k = 0; k < 4; k++) begin
        v[k]    = 8'($urandom());
        sel[k]  = 3'($urandom_range(0, 7));
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    // Hold a word, then pulse reset between edges.
    for (int k = 0; k < 4; k++) begin
      v[k] = 8'hFF; ordy[k] = 1'b0; sel[k] = 3'd1;
    end
    step();
    step();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v[k] = 8'b0101_0000; ordy[k] = 1'b1; sel[k] = 3'd4;
    end
    v[3] = 8'b0001_0100;
    for (int i = 0; i < 6; i++) begin
      new_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
